pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 192, payload width in bits (PC 32 + instruction 32 + cycle 64 + instret 64).
REQ-002 SHALL have parameter KEY_W, default 32, width of the bubble key field data[KEY_W-1:0]; 0 disables bubble filtering.
REQ-003 SHALL have parameter CNT_W, default 32, width of each statistics counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 SHALL have port in_ready, output, 1, stage can accept a beat; driven from registered state only.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port out_valid, output, 1, head entry present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the head.
REQ-011 SHALL have port out_data, output, DATA_W, head payload; all zeros when out_valid=0.
REQ-012 SHALL have port flush, input, 1, discards all held and incoming beats.
REQ-013 SHALL have port level, output, 2, occupancy 0..2.
REQ-014 SHALL have port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.
REQ-015 SHALL have port flush_cnt, output, CNT_W, cycles with flush=1.
REQ-016 SHALL have port drop_cnt, output, CNT_W, beats discarded by flush or the bubble filter.

Function
REQ-017 SHALL implement a 2-entry skid buffer (head, skid) with states EMPTY, ONE, FULL; level = 0/1/2 respectively.
REQ-018 SHALL define accept = in_valid & in_ready and consume = out_valid & out_ready.
REQ-019 SHALL drive in_ready=1 in EMPTY and ONE, 0 in FULL; out_valid=1 in ONE and FULL.
REQ-020 SHALL use latency of 1 cycle: a beat accepted in EMPTY appears on out_data with out_valid=1 in the next cycle.
REQ-021 SHALL apply these transitions when flush=0 and the accepted beat is kept: EMPTY+accept -> ONE; ONE+accept+!consume -> FULL (beat into skid); ONE+accept+consume -> ONE (beat into head); ONE+!accept+consume -> EMPTY; FULL+consume -> ONE (skid moves to head); otherwise hold.
REQ-022 SHALL keep the stored payload and state unchanged on stall (out_valid=1, out_ready=0).
REQ-023 SHALL, when KEY_W>0 and in_data[KEY_W-1:0]==0, treat the accepted beat as a bubble: handshake completes, beat is not stored, drop_cnt increments.
REQ-024 SHALL, on flush=1, go to EMPTY next cycle regardless of other inputs; an accept in the same cycle is discarded; a consume in the same cycle completes normally.
REQ-025 SHALL, on flush, increment drop_cnt by (entries held not consumed this cycle) + (1 if accept), i.e. 0..2.
REQ-026 SHALL deliver beats in acceptance order, with no duplication or loss other than REQ-023/REQ-024.
REQ-027 SHALL saturate all counters at 2^CNT_W-1 with no wrap.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set state EMPTY, level=0, in_ready=1, out_valid=0, out_data=0, all counters 0 in the next cycle; rst overrides flush and all handshakes.
REQ-029 SHALL discard held entries on reset mid-operation without counting them in drop_cnt.

Verification
REQ-030 SHALL test streaming: out_ready=1 constantly, send PC 0x04,0x08,0x0C back-to-back -> same order out, 1-cycle latency, level stays 1, stall_cnt=0.
REQ-031 SHALL test backpressure: out_ready=0, send 0x04,0x08,0x0C -> level=2, in_ready=0, 0x0C held upstream; after out_ready=1, output order 0x04,0x08,0x0C; stall_cnt = stalled cycles.
REQ-032 SHALL test flush when FULL with simultaneous accept blocked, then flush in ONE with accept and no consume -> EMPTY next cycle, out_data=0, drop_cnt=2 then 4, flush_cnt=2.
REQ-033 SHALL test bubble filtering with KEY_W=32: send PC 0x00000000 between 0x10 and 0x14 -> only 0x10,0x14 appear, drop_cnt=1; with KEY_W=0, PC 0 passes through.
REQ-034 SHALL test reset mid-operation: rst while FULL with counters nonzero -> next cycle level=0, out_valid=0, in_ready=1, all counters 0.
REQ-035 SHALL test saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer (head + skid) between pipeline stages.
// Filters bubble beats by key, supports flush, and keeps saturating statistics.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready comes from registered state
//   in_data             upstream payload, DATA_W bits
//   out_valid/out_ready downstream handshake on the head entry
//   out_data            head payload, zero when out_valid is low
//   flush               drops every held and incoming beat
//   level               occupancy 0..2
//   stall_cnt           cycles with out_valid=1 and out_ready=0
//   flush_cnt           cycles with flush=1
//   drop_cnt            beats discarded by flush or by the bubble filter
module pipe_skid_stage #(
    parameter int unsigned DATA_W = 192,
    parameter int unsigned KEY_W  = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] skid;
    logic              accept;
    logic              consume;
    logic              bubble;
    logic              keep;
    logic [1:0]        drop_inc;

    // A zero key marks a bubble; with KEY_W=0 nothing is filtered.
    generate
        if (KEY_W > 0) begin : g_key
            assign bubble = (in_data[KEY_W-1:0] == '0);
        end else begin : g_nokey
            assign bubble = 1'b0;
        end
    endgenerate

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    assign keep    = accept & ~bubble & ~flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (keep) state_nxt = ONE;
                ONE: begin
                    if (keep && !consume) begin
                        state_nxt = FULL;
                    end else if (!keep && consume) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL:    if (consume) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Outputs depend only on registered state
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        out_data  = out_valid ? head : '0;
        level     = state;
    end

    // Payload storage; in FULL in_ready is low so no new beat can arrive
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (keep) head <= in_data;
                ONE: begin
                    if (keep && consume) begin
                        head <= in_data;
                    end else if (keep) begin
                        skid <= in_data;
                    end
                end
                FULL:    if (consume) head <= skid;
                default: ;
            endcase
        end
    end

    // Flush drops what is held but not leaving this cycle, plus any accept
    always_comb begin
        if (flush) begin
            drop_inc = (level - {1'b0, consume}) + {1'b0, accept};
        end else begin
            drop_inc = {1'b0, accept & bubble};
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [1:0]       b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            stall_cnt <= sat_add(stall_cnt, {1'b0, out_valid & ~out_ready});
            flush_cnt <= sat_add(flush_cnt, {1'b0, flush});
            drop_cnt  <= sat_add(drop_cnt, drop_inc);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed bench for pipe_skid_stage with scoreboards.
// u0 default, u1 KEY_W=0, u2 CNT_W=4; all share the same stimulus.
module tb_pipe_skid_stage;

    localparam int DW = 192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;

    logic          r0, v0, r1, v1, r2, v2;
    logic [DW-1:0] d0, d1, d2;
    logic [1:0]    lvl0, lvl1, lvl2;
    logic [31:0]   st0, fl0, dr0, st1, fl1, dr1;
    logic [3:0]    st2, fl2, dr2;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    always #5 clk = ~clk;

    pipe_skid_stage u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .flush(flush), .level(lvl0),
        .stall_cnt(st0), .flush_cnt(fl0), .drop_cnt(dr0)
    );

    pipe_skid_stage #(.KEY_W(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .flush(flush), .level(lvl1),
        .stall_cnt(st1), .flush_cnt(fl1), .drop_cnt(dr1)
    );

    pipe_skid_stage #(.CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2),
        .in_data(in_data), .out_valid(v2), .out_ready(out_ready),
        .out_data(d2), .flush(flush), .level(lvl2),
        .stall_cnt(st2), .flush_cnt(fl2), .drop_cnt(dr2)
    );

    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        return {32'hC0DE_0000 ^ pc, {32'h0, pc} * 64'd7,
                {32'h0, pc} + 64'd100, pc};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every consumed head must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && v0 && out_ready) begin
            if (q0.size() == 0) chk("u0_extra_beat", 0, 1);
            else chk("u0_order", d0, q0.pop_front());
        end
        if (!rst && v1 && out_ready) begin
            if (q1.size() == 0) chk("u1_extra_beat", 0, 1);
            else chk("u1_order", d1, q1.pop_front());
        end
    end

    task automatic drive(input logic [31:0] pc);
        in_valid = 1'b1;
        in_data  = mk(pc);
        if (pc != 0) q0.push_back(mk(pc));
        q1.push_back(mk(pc));
    endtask

    task automatic wait_acc(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, DW'(ok), DW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_level", DW'(lvl0), 0);
        chk("rst_in_ready", DW'(r0), 1);
        chk("rst_out_valid", DW'(v0), 0);
        chk("rst_out_data", d0, 0);
        chk("rst_cnts", DW'({st0, fl0, dr0}), 0);

        // Streaming, out_ready held high
        do_reset();
        out_ready = 1'b1;
        drive(32'h04); cyc();
        drive(32'h08);
        @(negedge clk);
        chk("str_lat_valid", DW'(v0), 1);
        chk("str_lat_data", d0, mk(32'h04));
        chk("str_lvl_a", DW'(lvl0), 1);
        chk("str_rdy", DW'(r0), 1);
        cyc();
        drive(32'h0C);
        @(negedge clk);
        chk("str_lvl_b", DW'(lvl0), 1);
        chk("str_data_b", d0, mk(32'h08));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("str_lvl_c", DW'(lvl0), 1);
        chk("str_data_c", d0, mk(32'h0C));
        cyc();
        @(negedge clk);
        chk("str_lvl_end", DW'(lvl0), 0);
        chk("str_stall", DW'(st0), 0);
        chk("str_drained", DW'(q0.size()), 0);

        // Backpressure
        do_reset();
        drive(32'h04); cyc();
        drive(32'h08);
        @(negedge clk);
        chk("bp_lvl1", DW'(lvl0), 1);
        cyc();
        drive(32'h0C);
        @(negedge clk);
        chk("bp_lvl2", DW'(lvl0), 2);
        chk("bp_in_ready", DW'(r0), 0);
        chk("bp_head", d0, mk(32'h04));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_stall_hold", DW'(st0), 4);
        chk("bp_lvl_hold", DW'(lvl0), 2);
        cyc();
        out_ready = 1'b1;
        wait_acc("bp_c");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_stall_final", DW'(st0), 5);
        chk("bp_lvl_end", DW'(lvl0), 0);
        chk("bp_drained", DW'(q0.size()), 0);

        // Flush in FULL with a blocked accept, then in ONE with accept
        do_reset();
        drive(32'h04); cyc();
        drive(32'h08); cyc();
        in_valid = 1'b1;
        in_data = mk(32'h0C);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_full_rdy", DW'(r0), 0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl1_lvl", DW'(lvl0), 0);
        chk("fl1_valid", DW'(v0), 0);
        chk("fl1_data", d0, 0);
        chk("fl1_drop", DW'(dr0), 2);
        chk("fl1_fcnt", DW'(fl0), 1);
        q0.delete();
        q1.delete();
        drive(32'h10); cyc();
        in_valid = 1'b1;
        in_data = mk(32'h14);
        flush = 1'b1;
        @(negedge clk);
        chk("fl2_pre_lvl", DW'(lvl0), 1);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl2_lvl", DW'(lvl0), 0);
        chk("fl2_data", d0, 0);
        chk("fl2_drop", DW'(dr0), 4);
        chk("fl2_fcnt", DW'(fl0), 2);
        q0.delete();
        q1.delete();

        // Bubble filter: u0 drops PC 0, u1 passes it
        do_reset();
        out_ready = 1'b1;
        drive(32'h10); cyc();
        drive(32'h00); cyc();
        drive(32'h14); cyc();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bub_drop_k32", DW'(dr0), 1);
        chk("bub_drop_k0", DW'(dr1), 0);
        chk("bub_q0_empty", DW'(q0.size()), 0);
        chk("bub_q1_empty", DW'(q1.size()), 0);

        // Reset while FULL with nonzero counters
        do_reset();
        drive(32'h04); cyc();
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(32'h04); cyc();
        drive(32'h08); cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_lvl", DW'(lvl0), 2);
        chk("mid_cnts", DW'({st0, fl0, dr0}), DW'({32'd2, 32'd1, 32'd1}));
        in_valid = 1'b1;
        in_data = mk(32'h0C);
        flush = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("mrst_lvl", DW'(lvl0), 0);
        chk("mrst_valid", DW'(v0), 0);
        chk("mrst_rdy", DW'(r0), 1);
        chk("mrst_data", d0, 0);
        chk("mrst_cnts", DW'({st0, fl0, dr0}), 0);

        // Saturation with CNT_W=4
        do_reset();
        drive(32'h04); cyc();
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_stall_w4", DW'(st2), 15);
        chk("sat_stall_w32", DW'(st0), 20);

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
